act_scheduler: RTL and testbench

Sequences activation vectors from the activation buffer SRAM into the row inputs of the systolic array. On `start` it reads `num_vec` consecutive N-lane vectors from `base_addr` and injects each into the array with a diagonal skew: lane i is delayed i cycles. It also supports a global `stall` from the array controller and pulses `done` once the last skewed element has left. The block sits between the activation buffer and the array's west edge.

---
 rtl/act_sched_pkg.sv | 17 +
 rtl/act_scheduler_if.sv | 36 +++
 rtl/act_skew_line.sv | 37 +++
 rtl/act_scheduler.sv | 143 ++++++++++++++
 tb/tb_act_scheduler.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/act_sched_pkg.sv
// Shared types and default sizing for the activation scheduler.
package act_sched_pkg;

  localparam int ACT_N_DEF       = 4;
  localparam int ACT_DATA_W_DEF  = 8;
  localparam int ACT_AW_DEF      = 8;
  localparam int ACT_MAX_VEC_DEF = 255;
  localparam int ACT_VW_DEF      = $clog2(ACT_MAX_VEC_DEF + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } act_sched_state_t;

endpackage

// File: rtl/act_scheduler_if.sv
// Control, SRAM read port and array-side signals of the activation scheduler.
interface act_scheduler_if
  import act_sched_pkg::*;
#(
  parameter int N       = ACT_N_DEF,
  parameter int DATA_W  = ACT_DATA_W_DEF,
  parameter int AW      = ACT_AW_DEF,
  parameter int MAX_VEC = ACT_MAX_VEC_DEF,
  parameter int VW      = $clog2(MAX_VEC + 1)
);

  logic                start;
  logic [VW-1:0]       num_vec;
  logic [AW-1:0]       base_addr;
  logic                stall;
  logic                mem_rd_en;
  logic [AW-1:0]       mem_rd_addr;
  logic [N*DATA_W-1:0] mem_rd_data;
  logic [N*DATA_W-1:0] act_data;
  logic [N-1:0]        act_valid;
  logic                busy;
  logic                done;

  // scheduler side
  modport slave (
    input  start, num_vec, base_addr, stall, mem_rd_data,
    output mem_rd_en, mem_rd_addr, act_data, act_valid, busy, done
  );

  // controller / SRAM / array side
  modport master (
    output start, num_vec, base_addr, stall, mem_rd_data,
    input  mem_rd_en, mem_rd_addr, act_data, act_valid, busy, done
  );

endinterface

// File: rtl/act_skew_line.sv
// One lane's delay line: DEPTH register stages, frozen while en is low.
// Data is forced to zero whenever its valid bit is low.
module act_skew_line #(
  parameter int DEPTH  = 1,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic [DEPTH-1:0]             vld_q;
  logic [DEPTH-1:0][DATA_W-1:0] dat_q;

  // shift valid/data one stage per enabled cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      dat_q <= '0;
    end else if (en) begin
      vld_q[0] <= in_valid;
      dat_q[0] <= in_valid ? in_data : '0;
      for (int k = 1; k < DEPTH; k++) begin
        vld_q[k] <= vld_q[k-1];
        dat_q[k] <= dat_q[k-1];
      end
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_data  = dat_q[DEPTH-1];

endmodule

// File: rtl/act_scheduler.sv
// Activation scheduler: reads K vectors from the activation buffer and feeds
// them diagonally skewed (lane i delayed i cycles) into the array west edge.
//
//   state | meaning
//   IDLE  | waiting for start
//   FETCH | issuing one SRAM read per unstalled cycle
//   DRAIN | reads done, waiting for the last skewed element to leave
//   DONE  | one-cycle completion pulse
module act_scheduler
  import act_sched_pkg::*;
#(
  parameter int N       = ACT_N_DEF,
  parameter int DATA_W  = ACT_DATA_W_DEF,
  parameter int AW      = ACT_AW_DEF,
  parameter int MAX_VEC = ACT_MAX_VEC_DEF,
  parameter int VW      = $clog2(MAX_VEC + 1)
) (
  input  logic          clk,
  input  logic          rst,
  act_scheduler_if.slave bus
);

  localparam int DCW = $clog2(N + 1);

  act_sched_state_t    state_q, state_d;
  logic [VW-1:0]       rem_q;
  logic [AW-1:0]       addr_q;
  logic                rd_pend_q;
  logic                hold_vld_q;
  logic [N*DATA_W-1:0] hold_data_q;
  logic [DCW-1:0]      drain_q;
  logic                busy_q;
  logic                done_q;

  logic                run;
  logic                accept;
  logic                issue;
  logic                in_vld;
  logic [N*DATA_W-1:0] in_data;
  logic [N*DATA_W-1:0] act_data_w;
  logic [N-1:0]        act_valid_w;

  assign run     = !bus.stall;
  assign accept  = (state_q == IDLE) && bus.start;
  assign issue   = (state_q == FETCH) && run;
  // a parked word and a fresh return never coexist: stall suppresses issue
  assign in_vld  = rd_pend_q || hold_vld_q;
  assign in_data = hold_vld_q ? hold_data_q : bus.mem_rd_data;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next-state logic; FETCH/DRAIN only advance on unstalled cycles
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (bus.start) state_d = (bus.num_vec == '0) ? DONE : FETCH;
      FETCH: if (run && rem_q == VW'(1)) state_d = DRAIN;
      DRAIN: if (run && drain_q == DCW'(1)) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // remaining-read down-counter and wrapping read address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      addr_q <= '0;
    end else if (accept) begin
      rem_q  <= bus.num_vec;
      addr_q <= bus.base_addr;
    end else if (issue) begin
      rem_q  <= rem_q - VW'(1);
      addr_q <= addr_q + AW'(1);
    end
  end

  // track the single-cycle read latency; park returning data during a stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend_q   <= 1'b0;
      hold_vld_q  <= 1'b0;
      hold_data_q <= '0;
    end else begin
      rd_pend_q <= issue;
      if (bus.stall && rd_pend_q) begin
        hold_vld_q  <= 1'b1;
        hold_data_q <= bus.mem_rd_data;
      end else if (run) begin
        hold_vld_q  <= 1'b0;
      end
    end
  end

  // drain timer: the last vector enters the skew lines during DRAIN and
  // lane N-1 releases it N unstalled edges later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_q <= '0;
    end else if (run) begin
      if (state_q == DRAIN && in_vld) drain_q <= DCW'(N);
      else if (drain_q != '0)         drain_q <= drain_q - DCW'(1);
    end
  end

  // registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_d == FETCH) || (state_d == DRAIN);
      done_q <= (state_d == DONE);
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    act_skew_line #(
      .DEPTH  (i + 1),
      .DATA_W (DATA_W)
    ) u_skew (
      .clk       (clk),
      .rst       (rst),
      .en        (run),
      .in_valid  (in_vld),
      .in_data   (in_data[i*DATA_W +: DATA_W]),
      .out_valid (act_valid_w[i]),
      .out_data  (act_data_w[i*DATA_W +: DATA_W])
    );
  end

  assign bus.mem_rd_en   = issue;
  assign bus.mem_rd_addr = addr_q;
  assign bus.act_data    = act_data_w;
  assign bus.act_valid   = act_valid_w;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_act_scheduler.sv
// Scoreboard bench for act_scheduler: stimulus pushes expected reads, lane
// outputs and done pulses; a negedge monitor pops and compares them.
module tb_act_scheduler;
  import act_sched_pkg::*;

  localparam int N       = 4;
  localparam int DW      = 8;
  localparam int AW      = 8;
  localparam int MAX_VEC = 255;
  localparam int VW      = $clog2(MAX_VEC + 1);
  localparam int NO_STALL = 100000;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  act_scheduler_if #(.N(N), .DATA_W(DW), .AW(AW), .MAX_VEC(MAX_VEC)) bus();

  act_scheduler #(.N(N), .DATA_W(DW), .AW(AW), .MAX_VEC(MAX_VEC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // SRAM model: lane i of the word at address a holds a+i; filler when idle
  always @(posedge clk) begin
    for (int i = 0; i < N; i++)
      bus.mem_rd_data[i*DW +: DW] <= bus.mem_rd_en ? bus.mem_rd_addr + 8'(i) : 8'hEE;
  end

  typedef struct { int cyc; logic [7:0] addr; } rd_t;
  typedef struct { int cyc; int lane; logic [7:0] val; } act_t;

  rd_t  rd_q[$];
  act_t lane_q[$];
  int   done_q[$];
  int   busy_lo = 1, busy_hi = 0;
  int   done_seen = 0;
  int   n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_evt(input string name, input longint act);
    n_chk++;
    $display("FAIL %s: got 0x%0h required nothing (cycle %0d)", name, act, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sh(input int n, input int s_at, input int s_len);
    return (n >= s_at) ? n + s_len : n;
  endfunction

  // pulse start and push the expected response, shifted by any planned stall
  task automatic launch(input int k, input logic [7:0] base, input int s_at,
                        input int s_len, output int c0);
    c0 = cyc;
    bus.start     = 1'b1;
    bus.num_vec   = VW'(k);
    bus.base_addr = base;
    for (int j = 0; j < k; j++) begin
      rd_q.push_back('{c0 + sh(1 + j, s_at, s_len), base + 8'(j)});
      for (int i = 0; i < N; i++)
        lane_q.push_back('{c0 + sh(3 + j + i, s_at, s_len), i, base + 8'(j + i)});
    end
    busy_lo = c0 + 1;
    if (k == 0) begin
      busy_hi = c0;
      done_q.push_back(c0 + 1);
    end else begin
      busy_hi = c0 + sh(k + N + 1, s_at, s_len);
      done_q.push_back(c0 + sh(k + N + 2, s_at, s_len));
    end
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    while (done_q.size() != 0 && t < budget) begin
      tick();
      t++;
    end
    if (done_q.size() != 0) begin
      fail_evt("done_timeout", done_q.size());
      done_q.delete();
    end
    repeat (3) tick();
  endtask

  // monitor: compare everything the DUT presents against the scoreboard
  always @(negedge clk) begin : mon
    rd_t        r;
    act_t       e;
    int         idx;
    logic [7:0] lv;
    if (!rst) begin
      if (bus.mem_rd_en) begin
        if (rd_q.size() == 0) fail_evt("unexpected_read", bus.mem_rd_addr);
        else begin
          r = rd_q.pop_front();
          chk("rd_cycle", cyc, r.cyc);
          chk("rd_addr", bus.mem_rd_addr, r.addr);
        end
      end
      for (int i = 0; i < N; i++) begin
        lv = bus.act_data[i*DW +: DW];
        if (bus.act_valid[i]) begin
          if (!bus.stall) begin
            idx = -1;
            for (int k = 0; k < lane_q.size(); k++)
              if (idx < 0 && lane_q[k].lane == i) idx = k;
            if (idx < 0) fail_evt($sformatf("unexpected_act_lane%0d", i), lv);
            else begin
              e = lane_q[idx];
              lane_q.delete(idx);
              chk($sformatf("lane%0d_cycle", i), cyc, e.cyc);
              chk($sformatf("lane%0d_data", i), lv, e.val);
            end
          end
        end else begin
          chk($sformatf("lane%0d_idle_zero", i), lv, 0);
        end
      end
      if (bus.done) begin
        done_seen++;
        if (done_q.size() == 0) fail_evt("unexpected_done", 1);
        else chk("done_cycle", cyc, done_q.pop_front());
      end
      chk("busy", bus.busy, (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int c0;
    int d0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.num_vec   = '0;
    bus.base_addr = '0;
    bus.stall     = 1'b0;
    tick();
    tick();
    chk("rst_mem_rd_en", bus.mem_rd_en, 0);
    chk("rst_mem_rd_addr", bus.mem_rd_addr, 0);
    chk("rst_act_valid", bus.act_valid, 0);
    chk("rst_act_data", bus.act_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    rst = 1'b0;
    repeat (2) tick();

    // basic sequence
    d0 = done_seen;
    launch(3, 8'h10, NO_STALL, 0, c0);
    wait_idle(40);
    chk("basic_done_count", done_seen - d0, 1);

    // zero vectors, with stall held through IDLE and DONE
    bus.stall = 1'b1;
    launch(0, 8'h33, NO_STALL, 0, c0);
    tick();
    bus.stall = 1'b0;
    wait_idle(10);

    // stall over cycles 3-4 (cycle 3 returns vector 1)
    launch(3, 8'h10, 3, 2, c0);
    while (cyc < c0 + 3) tick();
    bus.stall = 1'b1;
    tick();
    tick();
    bus.stall = 1'b0;
    wait_idle(40);

    // wrap, start ignored while busy and in the DONE cycle
    d0 = done_seen;
    launch(3, 8'hFE, NO_STALL, 0, c0);
    while (cyc < c0 + 4) tick();
    bus.start = 1'b1; bus.num_vec = VW'(7); bus.base_addr = 8'h55;
    tick();
    bus.start = 1'b0;
    while (cyc < c0 + 9) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (15) tick();
    chk("ignored_start_done_count", done_seen - d0, 1);
    chk("ignored_start_no_reads_left", rd_q.size(), 0);

    // reset in the middle of FETCH
    launch(5, 8'h80, NO_STALL, 0, c0);
    tick();
    tick();
    busy_hi = c0 + 2;
    rst = 1'b1;
    #1;
    chk("midrst_mem_rd_en", bus.mem_rd_en, 0);
    chk("midrst_mem_rd_addr", bus.mem_rd_addr, 0);
    chk("midrst_act_valid", bus.act_valid, 0);
    chk("midrst_act_data", bus.act_data, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    rd_q.delete();
    lane_q.delete();
    done_q.delete();
    tick();
    tick();
    rst = 1'b0;
    tick();
    d0 = done_seen;
    launch(2, 8'h40, NO_STALL, 0, c0);
    wait_idle(40);
    chk("post_rst_done_count", done_seen - d0, 1);

    chk("leftover_reads", rd_q.size(), 0);
    chk("leftover_lane_outputs", lane_q.size(), 0);
    chk("leftover_done", done_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
